// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave byte engine working on synchronized, edge-decoded SPI pin strobes.
// Optional receive-overrun detection (rx_ack_i / overrun_o) is built when SPI_SLAVE_OVERRUN_EN is defined.
module spi_slave_shifter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  sysClk_i,
   input  logic                  reset_i,
   input  logic                  cs_sync_i,
   input  logic                  cs_fall_i,
   input  logic                  cs_rise_i,
   input  logic                  sclk_rise_i,
   input  logic                  sclk_fall_i,
   input  logic                  mosi_sync_i,
   output logic                  miso_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_load_i,
   output logic                  tx_empty_o,
`ifdef SPI_SLAVE_OVERRUN_EN
   input  logic                  rx_ack_i,
   output logic                  overrun_o,
`endif
   output logic                  busy_o
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;
   localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   logic [0:0]            state;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] hold;
   logic [DATA_WIDTH-1:0] rx_data;
   logic [DATA_WIDTH-1:0] next_tx;
   logic [DATA_WIDTH-1:0] rx_word;
   logic                  hold_full;
   logic                  boundary;
   logic                  rx_valid;
   logic                  load_ok;
   logic                  go_idle;
   logic                  start;
   logic                  rise_ev;
   logic                  fall_ev;
   logic                  last_bit;
   logic                  consume;

   // Strobe decoding in priority order: cs_rise > cs_fall > sclk_rise > sclk_fall.
   assign go_idle  = (state == SHIFT) && (cs_rise_i || cs_sync_i);
   assign start    = !go_idle && cs_fall_i;
   assign rise_ev  = (state == SHIFT) && !go_idle && !cs_fall_i && sclk_rise_i;
   assign fall_ev  = (state == SHIFT) && !go_idle && !cs_fall_i && !sclk_rise_i && sclk_fall_i;
   assign last_bit = rise_ev && (bit_cnt == LAST_BIT);
   assign consume  = start || (fall_ev && boundary);
   assign load_ok  = tx_load_i && !hold_full;
   assign next_tx  = hold_full ? hold : '0;
   assign rx_word  = {rx_shift[DATA_WIDTH-2:0], mosi_sync_i};

   always_ff @(posedge sysClk_i or posedge reset_i) begin
      if (reset_i) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         boundary <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (go_idle) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            boundary <= 1'b0;
         end else if (start) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= next_tx;
            boundary <= 1'b0;
         end else if (rise_ev) begin
            rx_shift <= rx_word;
            if (last_bit) begin
               rx_data  <= rx_word;
               rx_valid <= 1'b1;
               bit_cnt  <= '0;
               boundary <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + CW'(1);
            end
         end else if (fall_ev) begin
            if (boundary) begin
               tx_shift <= next_tx;
               boundary <= 1'b0;
            end else begin
               tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   // A consume sees the pre-load holding state; a coincident load then lands in the emptied register.
   always_ff @(posedge sysClk_i or posedge reset_i) begin
      if (reset_i) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         if (load_ok) begin
            hold <= tx_data_i;
         end
         if (consume) begin
            hold_full <= load_ok;
         end else if (load_ok) begin
            hold_full <= 1'b1;
         end
      end
   end

`ifdef SPI_SLAVE_OVERRUN_EN
   logic pending;
   logic overrun;

   always_ff @(posedge sysClk_i or posedge reset_i) begin
      if (reset_i) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (last_bit) begin
            pending <= 1'b1;
         end else if (rx_ack_i) begin
            pending <= 1'b0;
         end
         if (start) begin
            overrun <= 1'b0;
         end else if (last_bit && pending && !rx_ack_i) begin
            overrun <= 1'b1;
         end
      end
   end

   assign overrun_o = overrun;
`endif

   assign miso_o     = (state == SHIFT) ? tx_shift[DATA_WIDTH-1] : 1'b0;
   assign rx_data_o  = rx_data;
   assign rx_valid_o = rx_valid;
   assign tx_empty_o = !hold_full;
   assign busy_o     = (state == SHIFT);

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: drives decoded SPI strobes and checks words, MISO bits and flags.
// Overrun checks are compiled in when SPI_SLAVE_OVERRUN_EN is defined.
module tb_spi_slave_shifter;

   logic       clk = 1'b0;
   logic       rst;
   logic       cs_sync;
   logic       cs_fall;
   logic       cs_rise;
   logic       sclk_rise;
   logic       sclk_fall;
   logic       mosi;
   logic       miso;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_empty;
   logic       busy;
`ifdef SPI_SLAVE_OVERRUN_EN
   logic       rx_ack;
   logic       overrun;
`endif

   int         total = 0;
   int         bad = 0;
   int         valid_cnt = 0;
   int         exp_valid = 0;
   logic [7:0] last_rx = 8'h00;
   logic [7:0] miso_byte;

   spi_slave_shifter #(.DATA_WIDTH(8)) dut (
      .sysClk_i   (clk),
      .reset_i    (rst),
      .cs_sync_i  (cs_sync),
      .cs_fall_i  (cs_fall),
      .cs_rise_i  (cs_rise),
      .sclk_rise_i(sclk_rise),
      .sclk_fall_i(sclk_fall),
      .mosi_sync_i(mosi),
      .miso_o     (miso),
      .rx_data_o  (rx_data),
      .rx_valid_o (rx_valid),
      .tx_data_i  (tx_data),
      .tx_load_i  (tx_load),
      .tx_empty_o (tx_empty),
`ifdef SPI_SLAVE_OVERRUN_EN
      .rx_ack_i   (rx_ack),
      .overrun_o  (overrun),
`endif
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   // Every high cycle of rx_valid counts as a pulse, so a stretched strobe shows up as extra counts.
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         valid_cnt++;
         last_rx = rx_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic csLow();
      cs_fall = 1'b1;
      cs_sync = 1'b0;
      tick();
      cs_fall = 1'b0;
   endtask

   task automatic csHigh();
      cs_rise = 1'b1;
      cs_sync = 1'b1;
      tick();
      cs_rise = 1'b0;
      tick();
   endtask

   // load_mode 1 loads just after the final rising edge, 2 loads on the final falling edge.
   task automatic applyStimulus(input logic [7:0] mosi_byte, input int nbits, input int load_mode,
                                input logic [7:0] load_val, output logic [7:0] sampled);
      sampled = 8'h00;
      for (int k = 0; k < nbits; k++) begin
         sampled[7-k] = miso;
         mosi = mosi_byte[7-k];
         sclk_rise = 1'b1;
         tick();
         sclk_rise = 1'b0;
         if (k == nbits - 1 && load_mode == 1) begin
            tx_data = load_val;
            tx_load = 1'b1;
         end
         tick();
         tx_load = 1'b0;
         tick();
         tick();
         if (k == nbits - 1 && load_mode == 2) begin
            tx_data = load_val;
            tx_load = 1'b1;
         end
         sclk_fall = 1'b1;
         tick();
         sclk_fall = 1'b0;
         tx_load = 1'b0;
         tick();
         tick();
         tick();
      end
   endtask

   task automatic loadHolding(input logic [7:0] value);
      tx_data = value;
      tx_load = 1'b1;
      tick();
      tx_load = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      cs_sync = 1'b1;
      cs_fall = 1'b0;
      cs_rise = 1'b0;
      sclk_rise = 1'b0;
      sclk_fall = 1'b0;
      mosi = 1'b0;
      tx_data = 8'h00;
      tx_load = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      rx_ack = 1'b0;
`endif
      tick();
      tick();
      checkOutput("reset_miso", miso, 0);
      checkOutput("reset_rx_data", rx_data, 8'h00);
      checkOutput("reset_rx_valid", rx_valid, 0);
      checkOutput("reset_tx_empty", tx_empty, 1);
      checkOutput("reset_busy", busy, 0);
      rst = 1'b0;
      tick();

      // Single word with empty holding register
      csLow();
      checkOutput("t1_busy_rise", busy, 1);
      applyStimulus(8'hA5, 8, 0, 8'h00, miso_byte);
      exp_valid += 1;
      checkOutput("t1_miso_zero", miso_byte, 8'h00);
      checkOutput("t1_rx_data", rx_data, 8'hA5);
      checkOutput("t1_valid_cnt", valid_cnt, exp_valid);
      checkOutput("t1_tx_empty", tx_empty, 1);
      csHigh();
      checkOutput("t1_busy_fall", busy, 0);

      // Two-word burst with refill after the first word
      loadHolding(8'h3C);
      checkOutput("t2_tx_full", tx_empty, 0);
      csLow();
      checkOutput("t2_tx_consumed", tx_empty, 1);
      applyStimulus(8'h12, 8, 1, 8'hC3, miso_byte);
      exp_valid += 1;
      checkOutput("t2_miso_w0", miso_byte, 8'h3C);
      checkOutput("t2_rx_w0", last_rx, 8'h12);
      applyStimulus(8'h34, 8, 0, 8'h00, miso_byte);
      exp_valid += 1;
      checkOutput("t2_miso_w1", miso_byte, 8'hC3);
      checkOutput("t2_rx_w1", rx_data, 8'h34);
      checkOutput("t2_valid_cnt", valid_cnt, exp_valid);
      csHigh();

      // Abort after five rising edges, then a clean word
      csLow();
      applyStimulus(8'hFF, 5, 0, 8'h00, miso_byte);
      csHigh();
      checkOutput("t3_abort_busy", busy, 0);
      checkOutput("t3_abort_no_valid", valid_cnt, exp_valid);
      checkOutput("t3_abort_rx_held", rx_data, 8'h34);
      csLow();
      applyStimulus(8'h5A, 8, 0, 8'h00, miso_byte);
      exp_valid += 1;
      checkOutput("t3_after_abort_rx", rx_data, 8'h5A);
      checkOutput("t3_after_abort_cnt", valid_cnt, exp_valid);
      csHigh();

      // Load contention: full register ignores a new load; coincident load and consume sends zeros
      loadHolding(8'hAA);
      loadHolding(8'h55);
      checkOutput("t4_full", tx_empty, 0);
      csLow();
      applyStimulus(8'h00, 8, 2, 8'h77, miso_byte);
      exp_valid += 1;
      checkOutput("t4_miso_kept", miso_byte, 8'hAA);
      checkOutput("t4_coincide_full", tx_empty, 0);
      applyStimulus(8'h11, 8, 0, 8'h00, miso_byte);
      exp_valid += 1;
      checkOutput("t4_miso_zeros", miso_byte, 8'h00);
      checkOutput("t4_empty_again", tx_empty, 1);
      applyStimulus(8'h22, 8, 0, 8'h00, miso_byte);
      exp_valid += 1;
      checkOutput("t4_miso_late", miso_byte, 8'h77);
      checkOutput("t4_rx", rx_data, 8'h22);
      csHigh();

      // Asynchronous reset in the middle of a word
      loadHolding(8'h99);
      csLow();
      applyStimulus(8'hFF, 4, 0, 8'h00, miso_byte);
      rst = 1'b1;
      #1;
      checkOutput("t5_busy", busy, 0);
      checkOutput("t5_rx_data", rx_data, 8'h00);
      checkOutput("t5_rx_valid", rx_valid, 0);
      checkOutput("t5_tx_empty", tx_empty, 1);
      checkOutput("t5_miso", miso, 0);
      tick();
      rst = 1'b0;
      cs_sync = 1'b1;
      tick();
      checkOutput("t5_no_valid", valid_cnt, exp_valid);
      csLow();
      applyStimulus(8'h81, 8, 0, 8'h00, miso_byte);
      exp_valid += 1;
      checkOutput("t5_rx_81", rx_data, 8'h81);
      checkOutput("t5_valid_cnt", valid_cnt, exp_valid);
      csHigh();

`ifdef SPI_SLAVE_OVERRUN_EN
      // Clear the pending flag left by the earlier words
      rx_ack = 1'b1;
      tick();
      rx_ack = 1'b0;
      csLow();
      checkOutput("t6_ovr_start", overrun, 0);
      applyStimulus(8'h01, 8, 0, 8'h00, miso_byte);
      applyStimulus(8'h02, 8, 0, 8'h00, miso_byte);
      checkOutput("t6_overrun_set", overrun, 1);
      checkOutput("t6_rx_overwritten", rx_data, 8'h02);
      csHigh();
      checkOutput("t6_overrun_sticky", overrun, 1);
      rx_ack = 1'b1;
      tick();
      rx_ack = 1'b0;
      csLow();
      checkOutput("t6_overrun_clear", overrun, 0);
      applyStimulus(8'h03, 8, 0, 8'h00, miso_byte);
      rx_ack = 1'b1;
      tick();
      rx_ack = 1'b0;
      applyStimulus(8'h04, 8, 0, 8'h00, miso_byte);
      checkOutput("t6_acked_no_ovr", overrun, 0);
      csHigh();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
